prog_loader: RTL and testbench

Program loader and writable instruction store for the mini processor. It accepts a bit-serial program over a valid/ready link and writes it into a DEPTH×1 instruction memory. It holds the core in reset until a full program has landed, then serves `inst` to the core's `pc` read port. It is the write side of the instruction memory that the PC/ADD_SUB datapath only reads.

---
 rtl/mini_pro_pkg.sv | 26 ++
 rtl/inst_ram.sv | 35 +++
 rtl/prog_loader.sv | 160 ++++++++++++++++
 tb/tb_prog_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mini_pro_pkg.sv
// mini_pro_pkg: shared types and constants for the mini processor.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: loader FSM state enum, default instruction-store geometry,
// and the 1-bit instruction encoding used by the ADD_SUB datapath.
package mini_pro_pkg;

  // Default instruction store geometry: DEPTH 1-bit words, AW = log2(DEPTH).
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

  // One-bit instruction encoding consumed by ADD_SUB.
  localparam logic INST_ADD = 1'b0;
  localparam logic INST_SUB = 1'b1;

  // Loader states. PAR and ERR are only reachable in the parity build.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PAR  = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/inst_ram.sv
// inst_ram: DEPTH x 1 instruction memory, synchronous write, combinational read.
// Latency: a write is visible on rdata the cycle after we is sampled.
// Backpressure: none; a write is accepted every cycle we is high.
//
// Ports:
//   clk, rst        - clock, synchronous active-high clear of all words
//   we/waddr/wdata  - write port
//   raddr/rdata     - asynchronous read port
module inst_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  // Words are a single bit, so the whole store is one flat vector.
  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// prog_loader: bit-serial program loader and writable instruction store.
// Latency: 1 cycle per accepted bit; RUN one cycle after the final accepted bit.
// Backpressure: bit_ready is high only in LOAD/PAR; bits are ignored otherwise.
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   load_start                     - one-cycle pulse, (re)starts a load from any state
//   bit_in, bit_valid, bit_ready   - serial program link (valid/ready)
//   pc, inst                       - core instruction read port (combinational)
//   core_rst, done, err            - core reset, program running, load failed
//
// Build option: define PROG_LOADER_PARITY_EN to require a trailing even-parity
// bit after the data bits; a mismatch parks the loader in ERR.
module prog_loader
  import mini_pro_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  input  logic [AW-1:0] pc,
  output logic          inst,
  output logic          core_rst,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_addr;
  logic          ready_st;
  logic          xfer;
  logic          mem_we;
  logic          err_st;

  // Ready is decoded straight from the state register so the transfer
  // qualifier never loops back through the next-state logic.
  assign ready_st  = (state == LOAD) || (state == PAR);
  assign bit_ready = ready_st;
  assign xfer      = bit_valid & ready_st;

  // A restart in the same cycle as a transfer drops that transfer.
  assign mem_we = (state == LOAD) & xfer & ~load_start;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Write address counter (wraps naturally at DEPTH)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
    end else if (load_start) begin
      wr_addr <= '0;
    end else if (mem_we) begin
      wr_addr <= wr_addr + AW'(1);
    end
  end

`ifdef PROG_LOADER_PARITY_EN
  // Running XOR of the data bits; the trailing bit must equal it.
  logic par_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_acc <= 1'b0;
    end else if (load_start) begin
      par_acc <= 1'b0;
    end else if (mem_we) begin
      par_acc <= par_acc ^ bit_in;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Next state and Moore outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    core_rst  = 1'b1;
    done      = 1'b0;
    err_st    = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      LOAD: begin
        if (xfer && (wr_addr == LAST_ADDR)) begin
`ifdef PROG_LOADER_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = RUN;
`endif
        end
      end
`ifdef PROG_LOADER_PARITY_EN
      PAR: begin
        if (xfer) begin
          state_nxt = (bit_in == par_acc) ? RUN : ERR;
        end
      end
      ERR: begin
        err_st = 1'b1;
      end
`endif
      RUN: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Restart wins over every other transition, including the last bit.
    if (load_start) begin
      state_nxt = LOAD;
    end
  end

`ifdef PROG_LOADER_PARITY_EN
  assign err = err_st;
`else
  assign err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Instruction store
  // ---------------------------------------------------------------------
  inst_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_inst_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (bit_in),
    .raddr (pc),
    .rdata (inst)
  );

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed, table-driven bench for prog_loader.
// Latency: n/a.
// Backpressure: drives bit_valid patterns (continuous and toggled).
module tb_prog_loader;

  logic       clk;
  logic       rst;
  logic       load_start;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [3:0] pc;
  logic       inst;
  logic       core_rst;
  logic       done;
  logic       err;

  int total;
  int bad;

`ifdef PROG_LOADER_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .pc         (pc),
    .inst       (inst),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] data;
    bit          toggle;
    int          exp_cyc;
  } load_vec_t;

  load_vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; afterwards registered outputs reflect the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse load_start during the current cycle; returns in cycle 1 (LOAD).
  task automatic do_load_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Stream n bits of d LSB-first from cycle 1; returns the first cycle
  // where done or err is seen, or -1 if the cycle budget runs out.
  task automatic stream(input logic [16:0] d, input int n, input bit toggle,
                        output int end_cyc);
    int idx;
    idx = 0;
    end_cyc = -1;
    for (int c = 1; c < 100; c++) begin
      if (done || err) begin
        end_cyc = c;
        break;
      end
      bit_valid = (idx < n) && (!toggle || (c % 2 == 0));
      bit_in    = (idx < n) ? d[idx] : 1'b0;
      if (bit_valid && bit_ready) idx++;
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic sweep(input string name, input logic [15:0] exp);
    for (int i = 0; i < 16; i++) begin
      pc = i[3:0];
      #2;
      check(name, inst, exp[i]);
      tick();
    end
    pc = 4'd0;
  endtask

  initial begin
    int cyc;
    logic [15:0] d;

    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    load_start = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    pc         = 4'd0;

`ifdef PROG_LOADER_PARITY_EN
    vecs[0] = '{"a5c3_cont",   16'hA5C3, 1'b0, 18};
    vecs[1] = '{"a5c3_toggle", 16'hA5C3, 1'b1, 35};
    vecs[2] = '{"ffff_cont",   16'hFFFF, 1'b0, 18};
    vecs[3] = '{"3c96_toggle", 16'h3C96, 1'b1, 35};
`else
    vecs[0] = '{"a5c3_cont",   16'hA5C3, 1'b0, 17};
    vecs[1] = '{"a5c3_toggle", 16'hA5C3, 1'b1, 33};
    vecs[2] = '{"ffff_cont",   16'hFFFF, 1'b0, 17};
    vecs[3] = '{"3c96_toggle", 16'h3C96, 1'b1, 33};
`endif

    // Reset and idle.
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("idle_core_rst", core_rst, 1'b1);
      check("idle_done", done, 1'b0);
      check("idle_ready", bit_ready, 1'b0);
      check("idle_err", err, 1'b0);
      tick();
    end
    sweep("idle_inst", 16'h0000);

    // Table-driven loads, each restarted from the previous state.
    foreach (vecs[k]) begin
      d = vecs[k].data;
      do_load_start();
      check({vecs[k].name, "_load_core_rst"}, core_rst, 1'b1);
      check({vecs[k].name, "_load_ready"}, bit_ready, 1'b1);
      stream({^d, d}, NB, vecs[k].toggle, cyc);
      check({vecs[k].name, "_run_cycle"}, cyc, vecs[k].exp_cyc);
      check({vecs[k].name, "_done"}, done, 1'b1);
      check({vecs[k].name, "_core_rst"}, core_rst, 1'b0);
      check({vecs[k].name, "_ready"}, bit_ready, 1'b0);
      check({vecs[k].name, "_err"}, err, 1'b0);
      sweep({vecs[k].name, "_inst"}, d);
    end

    // Restart from RUN: core back in reset the next cycle, then 0xFFFF.
    do_load_start();
    check("rerun_core_rst", core_rst, 1'b1);
    check("rerun_done", done, 1'b0);
    stream({1'b0, 16'hFFFF}, NB, 1'b0, cyc);
    check("rerun_cycle", cyc, NB + 1);
    sweep("rerun_inst", 16'hFFFF);

    // Restart after 7 bits; the colliding transfer is dropped.
    do_load_start();
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      tick();
    end
    load_start = 1'b1;
    bit_valid  = 1'b1;
    bit_in     = 1'b1;
    tick();
    load_start = 1'b0;
    bit_valid  = 1'b0;
    check("abort_ready", bit_ready, 1'b1);
    check("abort_done", done, 1'b0);
    stream({1'b1, 16'h0001}, NB, 1'b0, cyc);
    check("abort_cycle", cyc, NB + 1);
    sweep("abort_inst", 16'h0001);

    // Synchronous reset in the middle of a load clears memory.
    do_load_start();
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    bit_valid = 1'b0;
    check("midrst_ready", bit_ready, 1'b0);
    check("midrst_core_rst", core_rst, 1'b1);
    check("midrst_done", done, 1'b0);
    sweep("midrst_inst", 16'h0000);

`ifdef PROG_LOADER_PARITY_EN
    // Good parity: three ones -> parity bit 1.
    do_load_start();
    stream({1'b1, 16'h0007}, 17, 1'b0, cyc);
    check("par_ok_cycle", cyc, 18);
    check("par_ok_done", done, 1'b1);
    check("par_ok_err", err, 1'b0);
    // Bad parity bit.
    do_load_start();
    stream({1'b0, 16'h0007}, 17, 1'b0, cyc);
    check("par_bad_cycle", cyc, 18);
    check("par_bad_err", err, 1'b1);
    check("par_bad_core_rst", core_rst, 1'b1);
    check("par_bad_done", done, 1'b0);
    check("par_bad_ready", bit_ready, 1'b0);
    do_load_start();
    check("par_clr_err", err, 1'b0);
    check("par_clr_ready", bit_ready, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
